// File: rtl/anabellek_hakemi.sv
// anabellek_hakemi: arbitrates instruction- and data-cache line requests
// onto a single 32-bit beat memory port, four beats per 128-bit line.
module anabellek_hakemi (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         bob_istek_i,
    input  logic [31:0]  bob_adres_i,
    input  logic         bob_iptal_i,
    output logic [127:0] bob_veri_o,
    output logic         bob_hazir_o,
    input  logic         vob_istek_i,
    input  logic         vob_yaz_i,
    input  logic [31:0]  vob_adres_i,
    input  logic [127:0] vob_yaz_veri_i,
    output logic [127:0] vob_veri_o,
    output logic         vob_hazir_o,
    output logic         bellek_istek_o,
    output logic         bellek_yaz_o,
    output logic [31:0]  bellek_adres_o,
    output logic [31:0]  bellek_yaz_veri_o,
    input  logic         bellek_hazir_i,
    input  logic [31:0]  bellek_veri_i,
    output logic         mesgul_o
);

    typedef enum logic [2:0] {
        BOSTA,
        BUYRUK_OKU,
        VERI_OKU,
        VERI_YAZ,
        TAMAM
    } durum_t;

    durum_t       durum_q, durum_d;
    logic [1:0]   beat_q, beat_d;
    logic         iptal_q, iptal_d;
    logic         son_vob_q, son_vob_d;
    logic         sahip_vob_q, sahip_vob_d;
    logic [31:0]  adres_q, adres_d;
    logic [127:0] yveri_q, yveri_d;
    logic [127:0] hat_q, hat_d;

    logic aktarim;
    logic bob_uygun;
    logic vob_uygun;
    logic bob_ver;
    logic vob_ver;

    assign aktarim   = (durum_q == BUYRUK_OKU) ||
                       (durum_q == VERI_OKU) ||
                       (durum_q == VERI_YAZ);
    assign bob_uygun = bob_istek_i & ~bob_iptal_i;
    assign vob_uygun = vob_istek_i;
    // On a tie the side that did not win last time gets the grant.
    assign bob_ver   = bob_uygun & (~vob_uygun | son_vob_q);
    assign vob_ver   = vob_uygun & ~bob_ver;

    // Next-state: arbitration, beat sequencing, line assembly, cancel flag.
    always_comb begin
        durum_d     = durum_q;
        beat_d      = beat_q;
        iptal_d     = iptal_q;
        son_vob_d   = son_vob_q;
        sahip_vob_d = sahip_vob_q;
        adres_d     = adres_q;
        yveri_d     = yveri_q;
        hat_d       = hat_q;
        unique case (durum_q)
            BOSTA: begin
                beat_d  = 2'd0;
                iptal_d = 1'b0;
                if (bob_ver) begin
                    sahip_vob_d = 1'b0;
                    adres_d     = bob_adres_i & 32'hFFFF_FFF0;
                    durum_d     = BUYRUK_OKU;
                end else if (vob_ver) begin
                    sahip_vob_d = 1'b1;
                    adres_d     = vob_adres_i & 32'hFFFF_FFF0;
                    if (vob_yaz_i) begin
                        yveri_d = vob_yaz_veri_i;
                        durum_d = VERI_YAZ;
                    end else begin
                        durum_d = VERI_OKU;
                    end
                end
            end
            BUYRUK_OKU, VERI_OKU, VERI_YAZ: begin
                if ((durum_q == BUYRUK_OKU) && bob_iptal_i) begin
                    iptal_d = 1'b1;
                end
                if (bellek_hazir_i) begin
                    beat_d = beat_q + 2'd1;
                    if (durum_q != VERI_YAZ) begin
                        hat_d[{beat_q, 5'b0} +: 32] = bellek_veri_i;
                    end
                    if (beat_q == 2'd3) begin
                        durum_d = TAMAM;
                    end
                end
            end
            TAMAM: begin
                son_vob_d = sahip_vob_q;
                iptal_d   = 1'b0;
                durum_d   = BOSTA;
            end
            default: begin
                durum_d = BOSTA;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            durum_q     <= BOSTA;
            beat_q      <= 2'd0;
            iptal_q     <= 1'b0;
            son_vob_q   <= 1'b1;
            sahip_vob_q <= 1'b0;
            adres_q     <= '0;
            yveri_q     <= '0;
            hat_q       <= '0;
        end else begin
            durum_q     <= durum_d;
            beat_q      <= beat_d;
            iptal_q     <= iptal_d;
            son_vob_q   <= son_vob_d;
            sahip_vob_q <= sahip_vob_d;
            adres_q     <= adres_d;
            yveri_q     <= yveri_d;
            hat_q       <= hat_d;
        end
    end

    assign mesgul_o          = (durum_q != BOSTA);
    assign bellek_istek_o    = aktarim;
    assign bellek_yaz_o      = (durum_q == VERI_YAZ);
    assign bellek_adres_o    = aktarim ? {adres_q[31:4], beat_q, 2'b00}
                                       : 32'h0;
    assign bellek_yaz_veri_o = (durum_q == VERI_YAZ)
                             ? yveri_q[{beat_q, 5'b0} +: 32] : 32'h0;
    // A cancel arriving in the completion cycle itself also suppresses it.
    assign bob_hazir_o       = (durum_q == TAMAM) & ~sahip_vob_q &
                               ~iptal_q & ~bob_iptal_i;
    assign vob_hazir_o       = (durum_q == TAMAM) & sahip_vob_q;
    assign bob_veri_o        = hat_q;
    assign vob_veri_o        = hat_q;

endmodule

// File: tb/tb_anabellek_hakemi.sv
// Scoreboard bench for anabellek_hakemi: directed line transfers,
// arbitration, write-back, cancellation and mid-burst reset.
module tb_anabellek_hakemi;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         bob_istek_i;
    logic [31:0]  bob_adres_i;
    logic         bob_iptal_i;
    logic [127:0] bob_veri_o;
    logic         bob_hazir_o;
    logic         vob_istek_i;
    logic         vob_yaz_i;
    logic [31:0]  vob_adres_i;
    logic [127:0] vob_yaz_veri_i;
    logic [127:0] vob_veri_o;
    logic         vob_hazir_o;
    logic         bellek_istek_o;
    logic         bellek_yaz_o;
    logic [31:0]  bellek_adres_o;
    logic [31:0]  bellek_yaz_veri_o;
    logic         bellek_hazir_i;
    logic [31:0]  bellek_veri_i;
    logic         mesgul_o;

    anabellek_hakemi dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .bob_istek_i      (bob_istek_i),
        .bob_adres_i      (bob_adres_i),
        .bob_iptal_i      (bob_iptal_i),
        .bob_veri_o       (bob_veri_o),
        .bob_hazir_o      (bob_hazir_o),
        .vob_istek_i      (vob_istek_i),
        .vob_yaz_i        (vob_yaz_i),
        .vob_adres_i      (vob_adres_i),
        .vob_yaz_veri_i   (vob_yaz_veri_i),
        .vob_veri_o       (vob_veri_o),
        .vob_hazir_o      (vob_hazir_o),
        .bellek_istek_o   (bellek_istek_o),
        .bellek_yaz_o     (bellek_yaz_o),
        .bellek_adres_o   (bellek_adres_o),
        .bellek_yaz_veri_o(bellek_yaz_veri_o),
        .bellek_hazir_i   (bellek_hazir_i),
        .bellek_veri_i    (bellek_veri_i),
        .mesgul_o         (mesgul_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [127:0] LINE_A = 128'h000000A3_000000A2_000000A1_000000A0;
    localparam logic [127:0] LINE_2 = 128'h5A5A200C_5A5A2008_5A5A2004_5A5A2000;
    localparam logic [127:0] LINE_4 = 128'h5A5A400C_5A5A4008_5A5A4004_5A5A4000;
    localparam logic [127:0] LINE_5 = 128'h5A5A500C_5A5A5008_5A5A5004_5A5A5000;
    localparam logic [127:0] WB     = 128'h44444444_33333333_22222222_11111111;

    typedef struct {
        bit           vob;
        logic [127:0] veri;
    } sb_t;

    typedef struct {
        bit          yaz;
        logic [31:0] adr;
        logic [31:0] wd;
    } bt_t;

    sb_t sbq[$];
    bt_t bq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nbeat = 0;
    int mode  = 0;
    int hcnt  = 0;

    task automatic chk(input string nm, input logic [127:0] a,
                       input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic push_beats(input bit y, input logic [31:0] ln,
                              input logic [127:0] wd, input int n);
        for (int k = 0; k < n; k++) begin
            bt_t b;
            b.yaz = y;
            b.adr = ln + 32'(4 * k);
            b.wd  = y ? wd[32*k +: 32] : 32'h0;
            bq.push_back(b);
        end
    endtask

    task automatic push_sb(input bit v, input logic [127:0] d);
        sb_t s;
        s.vob  = v;
        s.veri = d;
        sbq.push_back(s);
    endtask

    task automatic wait_hz(input bit v);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk_i);
            if (v ? vob_hazir_o : bob_hazir_o) ok = 1'b1;
        end
        if (v) vob_istek_i = 1'b0;
        else   bob_istek_i = 1'b0;
        chk(v ? "vob_done_seen" : "bob_done_seen", 128'(ok), 128'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {bob_hazir_o, vob_hazir_o, bellek_istek_o,
                            bellek_yaz_o, mesgul_o}, 128'd0);
        chk({tag, "_mem"}, {bellek_adres_o, bellek_yaz_veri_o}, 128'd0);
        chk({tag, "_bveri"}, bob_veri_o, 128'd0);
        chk({tag, "_vveri"}, vob_veri_o, 128'd0);
    endtask

    // memory read data
    always_comb begin
        if (bellek_adres_o[31:4] == 28'h123)
            bellek_veri_i = 32'hA0 + {30'b0, bellek_adres_o[3:2]};
        else
            bellek_veri_i = {16'h5A5A, bellek_adres_o[15:0]};
    end

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // memory beat-ready pattern
    initial begin
        bellek_hazir_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            if (mode == 0) begin
                bellek_hazir_i = 1'b1;
            end else begin
                hcnt++;
                bellek_hazir_i = (hcnt % 3 == 0);
            end
        end
    end

    // beat monitor
    initial begin
        bt_t b;
        forever begin
            @(negedge clk_i);
            if (bellek_istek_o && bellek_hazir_i) begin
                nbeat++;
                if (bq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_extra: got adr %h want none",
                             bellek_adres_o);
                end else begin
                    b = bq.pop_front();
                    chk("beat_yaz", 128'(bellek_yaz_o), 128'(b.yaz));
                    chk("beat_adr", 128'(bellek_adres_o), 128'(b.adr));
                    chk("beat_wd", 128'(bellek_yaz_veri_o), 128'(b.wd));
                end
            end
        end
    end

    // completion monitor
    initial begin
        sb_t s;
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk_i);
            if (bob_hazir_o || vob_hazir_o) begin
                chk("hz_one_cycle", 128'(prev), 128'd0);
                chk("hz_exclusive", 128'(bob_hazir_o & vob_hazir_o), 128'd0);
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL hz_extra: got bob=%0b vob=%0b want none",
                             bob_hazir_o, vob_hazir_o);
                end else begin
                    s = sbq.pop_front();
                    chk("hz_side", 128'(vob_hazir_o), 128'(s.vob));
                    chk("hz_veri", s.vob ? vob_veri_o : bob_veri_o, s.veri);
                end
            end
            prev = bob_hazir_o | vob_hazir_o;
        end
    end

    initial begin
        int c0;
        int base;
        bit ok;
        rst_i          = 1'b0;
        bob_istek_i    = 1'b0;
        bob_adres_i    = '0;
        bob_iptal_i    = 1'b0;
        vob_istek_i    = 1'b0;
        vob_yaz_i      = 1'b0;
        vob_adres_i    = '0;
        vob_yaz_veri_i = '0;

        repeat (3) @(negedge clk_i);
        chk_zero("rst");
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("idle_mesgul", 128'(mesgul_o), 128'd0);

        // simultaneous requests: instruction first, then alternation
        for (int r = 0; r < 2; r++) begin
            @(negedge clk_i);
            bob_istek_i = 1'b1;
            bob_adres_i = 32'h0000_1234;
            vob_istek_i = 1'b1;
            vob_yaz_i   = 1'b0;
            vob_adres_i = 32'h0000_2000;
            push_sb(1'b0, LINE_A);
            push_beats(1'b0, 32'h1230, '0, 4);
            push_sb(1'b1, LINE_2);
            push_beats(1'b0, 32'h2000, '0, 4);
            wait_hz(1'b0);
            wait_hz(1'b1);
        end

        // single read, minimum latency
        @(negedge clk_i);
        bob_istek_i = 1'b1;
        bob_adres_i = 32'h0000_1234;
        c0 = cyc;
        push_sb(1'b0, LINE_A);
        push_beats(1'b0, 32'h1230, '0, 4);
        wait_hz(1'b0);
        chk("latency", 128'(cyc - c0), 128'd5);
        @(negedge clk_i);
        chk("back_idle", {mesgul_o, bellek_istek_o}, 128'd0);

        // write-back leaves the line buffer alone
        @(negedge clk_i);
        vob_istek_i    = 1'b1;
        vob_yaz_i      = 1'b1;
        vob_adres_i    = 32'h0000_3000;
        vob_yaz_veri_i = WB;
        push_sb(1'b1, LINE_A);
        push_beats(1'b1, 32'h3000, WB, 4);
        wait_hz(1'b1);
        vob_yaz_i = 1'b0;

        // cancelled instruction read on a slow memory
        @(negedge clk_i);
        mode = 1;
        hcnt = 0;
        bob_istek_i = 1'b1;
        bob_adres_i = 32'h0000_5008;
        push_beats(1'b0, 32'h5000, '0, 4);
        base = nbeat;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk_i);
            if (nbeat >= base + 2) ok = 1'b1;
        end
        chk("cancel_two_beats", 128'(ok), 128'd1);
        bob_iptal_i = 1'b1;
        bob_istek_i = 1'b0;
        @(negedge clk_i);
        bob_iptal_i = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk_i);
            if (!mesgul_o) ok = 1'b1;
        end
        chk("cancel_idle", 128'(ok), 128'd1);
        chk("cancel_beats", 128'(nbeat - base), 128'd4);
        mode = 0;
        @(negedge clk_i);
        bob_istek_i = 1'b1;
        bob_adres_i = 32'h0000_5000;
        push_sb(1'b0, LINE_5);
        push_beats(1'b0, 32'h5000, '0, 4);
        wait_hz(1'b0);

        // reset during beat 2 of a data read
        @(negedge clk_i);
        vob_istek_i = 1'b1;
        vob_yaz_i   = 1'b0;
        vob_adres_i = 32'h0000_4000;
        push_beats(1'b0, 32'h4000, '0, 3);
        repeat (3) @(negedge clk_i);
        rst_i       = 1'b0;
        vob_istek_i = 1'b0;
        @(negedge clk_i);
        chk_zero("midrst");
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_idle", 128'(mesgul_o), 128'd0);
        vob_istek_i = 1'b1;
        vob_adres_i = 32'h0000_4000;
        push_sb(1'b1, LINE_4);
        push_beats(1'b0, 32'h4000, '0, 4);
        wait_hz(1'b1);

        repeat (3) @(negedge clk_i);
        chk("sb_drained", 128'(sbq.size()), 128'd0);
        chk("beats_drained", 128'(bq.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
